// File: rtl/mod53_pkg.sv
// Shared constants and FSM state type for the mod-53 Horner reducer.
package mod53_pkg;

    localparam int unsigned MOD     = 53;
    localparam int unsigned RES_W   = 6;
    localparam int unsigned CHUNK_W = 6;
    localparam int unsigned MUL64   = 11;   // 64 mod 53

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod53_mul11.sv
// Combinational lookup z = (11 * x) mod 53, i.e. a residue shifted left by
// one 6-bit chunk. Codes 53..63 are not valid residues and map to 0.
// Ports: x0..x5 input bits (x0 = LSB), z0..z5 output bits (z0 = LSB).
module mod53_mul11 (
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic x5,
    output logic z0,
    output logic z1,
    output logic z2,
    output logic z3,
    output logic z4,
    output logic z5
);

    logic [5:0] x;
    logic [5:0] z;

    assign x = {x5, x4, x3, x2, x1, x0};
    assign {z5, z4, z3, z2, z1, z0} = z;

    // Table of (11*x) mod 53
    always_comb begin
        z = 6'd0;
        case (x)
            6'd0:  z = 6'd0;
            6'd1:  z = 6'd11;
            6'd2:  z = 6'd22;
            6'd3:  z = 6'd33;
            6'd4:  z = 6'd44;
            6'd5:  z = 6'd2;
            6'd6:  z = 6'd13;
            6'd7:  z = 6'd24;
            6'd8:  z = 6'd35;
            6'd9:  z = 6'd46;
            6'd10: z = 6'd4;
            6'd11: z = 6'd15;
            6'd12: z = 6'd26;
            6'd13: z = 6'd37;
            6'd14: z = 6'd48;
            6'd15: z = 6'd6;
            6'd16: z = 6'd17;
            6'd17: z = 6'd28;
            6'd18: z = 6'd39;
            6'd19: z = 6'd50;
            6'd20: z = 6'd8;
            6'd21: z = 6'd19;
            6'd22: z = 6'd30;
            6'd23: z = 6'd41;
            6'd24: z = 6'd52;
            6'd25: z = 6'd10;
            6'd26: z = 6'd21;
            6'd27: z = 6'd32;
            6'd28: z = 6'd43;
            6'd29: z = 6'd1;
            6'd30: z = 6'd12;
            6'd31: z = 6'd23;
            6'd32: z = 6'd34;
            6'd33: z = 6'd45;
            6'd34: z = 6'd3;
            6'd35: z = 6'd14;
            6'd36: z = 6'd25;
            6'd37: z = 6'd36;
            6'd38: z = 6'd47;
            6'd39: z = 6'd5;
            6'd40: z = 6'd16;
            6'd41: z = 6'd27;
            6'd42: z = 6'd38;
            6'd43: z = 6'd49;
            6'd44: z = 6'd7;
            6'd45: z = 6'd18;
            6'd46: z = 6'd29;
            6'd47: z = 6'd40;
            6'd48: z = 6'd51;
            6'd49: z = 6'd9;
            6'd50: z = 6'd20;
            6'd51: z = 6'd31;
            6'd52: z = 6'd42;
            default: z = 6'd0;
        endcase
    end

endmodule

// File: rtl/mod53_horner_seq.sv
// Sequential mod-53 reducer: walks the operand one 6-bit chunk per cycle,
// MSB first, using r <= (r*64 + chunk) mod 53 with 64 mod 53 = 11.
// Ports: clk, rst_n (async, active-low), flush (sync abort),
//        in_valid/in_ready/in_data operand handshake,
//        out_valid/out_ready/out_data residue handshake, busy (RUN or DONE).
module mod53_horner_seq
    import mod53_pkg::*;
#(
    parameter int unsigned NCHUNK = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHUNK_W*NCHUNK-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [RES_W-1:0]            out_data,
    output logic                        busy
);

    localparam int unsigned IN_W  = CHUNK_W * NCHUNK;
    localparam int unsigned CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SUM_W = RES_W + 1;

    if (NCHUNK < 2 || NCHUNK > 8) begin : g_bad_nchunk
        $error("mod53_horner_seq: NCHUNK must be in 2..8");
    end

    state_t             state_q, state_d;
    logic [IN_W-1:0]    opnd_q, opnd_d;
    logic [RES_W-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_d, out_valid_d, busy_d;
    logic [RES_W-1:0]   out_data_d;

    logic [RES_W-1:0]   mul_r;
    logic [CHUNK_W-1:0] chunk;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   red1;
    logic [RES_W-1:0]   red2;

    // r * 64 mod 53
    mod53_mul11 u_mul11 (
        .x0 (r_q[0]),
        .x1 (r_q[1]),
        .x2 (r_q[2]),
        .x3 (r_q[3]),
        .x4 (r_q[4]),
        .x5 (r_q[5]),
        .z0 (mul_r[0]),
        .z1 (mul_r[1]),
        .z2 (mul_r[2]),
        .z3 (mul_r[3]),
        .z4 (mul_r[4]),
        .z5 (mul_r[5])
    );

    // Operand is shifted left each RUN cycle, so the current chunk is always on top
    assign chunk = opnd_q[IN_W-1 -: CHUNK_W];

    // Sum peaks at 52 + 63 = 115, so two conditional subtractions suffice
    always_comb begin
        sum  = SUM_W'(mul_r) + SUM_W'(chunk);
        red1 = (sum >= SUM_W'(MOD)) ? (sum - SUM_W'(MOD)) : sum;
        red2 = (red1 >= SUM_W'(MOD)) ? RES_W'(red1 - SUM_W'(MOD)) : RES_W'(red1);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        r_d     = r_q;
        cnt_d   = cnt_q;

        if (flush) begin
            state_d = ST_IDLE;
            opnd_d  = '0;
            r_d     = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        opnd_d  = in_data;
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_d    = red2;
                    opnd_d = opnd_q << CHUNK_W;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they track it exactly
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        out_data_d  = (state_d == ST_DONE) ? r_d : '0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opnd_q    <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mod53_horner_seq.sv
// Directed and random checks for mod53_horner_seq (NCHUNK = 4).
module tb_mod53_horner_seq;

    localparam int unsigned NCHUNK = 4;
    localparam int unsigned IN_W   = 6 * NCHUNK;
    localparam int          NOPS   = 5000;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_data;
    logic            busy;

    int checks;
    int failures;

    mod53_horner_seq #(.NCHUNK(NCHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Offer one operand, wait for its result, hold out_ready low for 'hold' cycles.
    // lat is the number of cycles from the accept edge to out_valid (20 on timeout).
    task automatic do_op(input logic [IN_W-1:0] d, input int hold,
                         output logic [5:0] res, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_data;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 6'd0) begin failures++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got in_ready=%b busy=%b expected 1 0", in_ready, busy); end
    endtask

    task automatic test_zero();
        logic [5:0] res;
        int lat;
        do_op(24'd0, 0, res, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL zero_latency: got %0d expected 4", lat); end
        checks++; if (res !== 6'd0) begin failures++; $display("FAIL zero_result: got %0d expected 0", res); end
    endtask

    task automatic test_vectors();
        logic [IN_W-1:0] vin  [6];
        logic [5:0]      vexp [6];
        logic [5:0]      res;
        int lat;
        vin[0] = 24'hFFFFFF; vexp[0] = 6'd12;
        vin[1] = 24'd53;     vexp[1] = 6'd0;
        vin[2] = 24'd52;     vexp[2] = 6'd52;
        vin[3] = 24'd1000000; vexp[3] = 6'd49;
        vin[4] = 24'h123456; vexp[4] = 6'd16;
        vin[5] = 24'hABCDEF; vexp[5] = 6'd2;
        for (int i = 0; i < 6; i++) begin
            do_op(vin[i], i % 3, res, lat);
            checks++; if (res !== vexp[i]) begin failures++; $display("FAIL vector_%0d_result: got %0d expected %0d", i, res, vexp[i]); end
            checks++; if (lat !== 4) begin failures++; $display("FAIL vector_%0d_latency: got %0d expected 4", i, lat); end
        end
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 24'hFFFFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 24'h000035;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_%0d_out_valid: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== 6'd12) begin failures++; $display("FAIL stall_%0d_out_data: got %0d expected 12", i, out_data); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_%0d_in_ready: got %b expected 0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_release_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 6'd0) begin failures++; $display("FAIL stall_release_out_data: got %0d expected 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_flush();
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 24'hFFFFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL flush_run_entry: got busy=%b in_ready=%b expected 1 0", busy, in_ready); end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_abort: got in_ready=%b busy=%b out_valid=%b expected 1 0 0", in_ready, busy, out_valid); end
        in_valid = 1'b1;
        in_data  = 24'd52;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL flush_blocks_accept: got in_ready=%b busy=%b expected 1 0", in_ready, busy); end
        flush = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL flush_next_accept: got in_ready=%b busy=%b expected 0 1", in_ready, busy); end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 4) begin failures++; $display("FAIL flush_followup_latency: got %0d expected 4", lat); end
        checks++; if (out_data !== 6'd52) begin failures++; $display("FAIL flush_followup_result: got %0d expected 52", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [5:0] res;
        int lat;
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 24'hABCDEF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0 || out_data !== 6'd0) begin failures++; $display("FAIL async_outputs: got out_valid=%b out_data=%0d expected 0 0", out_valid, out_data); end
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL async_no_output: got %0d valid cycles expected 0", seen); end
        do_op(24'd1000000, 1, res, lat);
        checks++; if (res !== 6'd49) begin failures++; $display("FAIL async_next_result: got %0d expected 49", res); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL async_next_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_random();
        logic [IN_W-1:0] sb_q [$];
        logic [IN_W-1:0] d;
        logic [IN_W-1:0] exp_in;
        logic [5:0]      res;
        logic [5:0]      exp_res;
        int lat;
        int results;
        results = 0;
        for (int i = 0; i < NOPS; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d = IN_W'($urandom);
            sb_q.push_back(d);
            do_op(d, int'($urandom_range(0, 3)), res, lat);
            exp_in  = sb_q.pop_front();
            exp_res = 6'(32'(exp_in) % 32'd53);
            results++;
            checks++; if (res !== exp_res || lat !== 4) begin failures++; $display("FAIL random_%0d: in=%h got %0d lat %0d expected %0d lat 4", i, exp_in, res, lat, exp_res); end
        end
        checks++; if (results !== NOPS || sb_q.size() !== 0) begin failures++; $display("FAIL random_count: got %0d results %0d pending expected %0d 0", results, sb_q.size(), NOPS); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero();
        test_vectors();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
